// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: the active-high
// hex glyph table and the digit-index width helper.
package display_scanner_pkg;

   // Segments a..g live at bits 0..6; a set bit lights the segment.
   localparam logic [6:0] SEG_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Load-side bus of the display scanner: new display contents plus the
// single-cycle strobe that captures them.
interface display_scanner_if #(
   parameter int NUM_DIGITS = 8,
   parameter int DIM_BITS   = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_mask;
   logic [DIM_BITS-1:0]     brightness;

   modport master (output load, digits_in, dp_in, digit_mask, brightness);
   modport slave  (input  load, digits_in, dp_in, digit_mask, brightness);
endinterface

// File: rtl/display_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
module hex_to_seg7
   import display_scanner_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = SEG_GLYPH[nibble];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner with per-digit blanking, PWM dimming and
// frame-synchronous double-buffered display data.
module display_scanner
   import display_scanner_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int DIM_BITS    = 4,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   display_scanner_if.slave      bus,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_tick
);

   localparam int          IW   = idx_width(NUM_DIGITS);
   localparam int          PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned STEP = REFRESH_DIV / (1 << DIM_BITS);
   localparam logic        OFF  = (ACTIVE_LOW != 0);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic                    slot_end;
   logic                    frame_end;

   logic [4*NUM_DIGITS-1:0] sh_digits,  act_digits;
   logic [NUM_DIGITS-1:0]   sh_dp,      act_dp;
   logic [NUM_DIGITS-1:0]   sh_mask,    act_mask;
   logic [DIM_BITS-1:0]     sh_bright,  act_bright;

   logic [31:0]             on_limit;
   logic                    lit;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic [3:0]              cur_nib;
   logic [6:0]              glyph;

   assign slot_end  = en && (presc == PW'(REFRESH_DIV - 1));
   assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (en) begin
         if (slot_end) begin
            presc <= '0;
            idx   <= frame_end ? '0 : idx + IW'(1);
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // A load on the wrap cycle bypasses the shadow so it lands in this frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_digits  <= '0;
         sh_dp      <= '0;
         sh_mask    <= '0;
         sh_bright  <= '1;
         act_digits <= '0;
         act_dp     <= '0;
         act_mask   <= '0;
         act_bright <= '1;
      end else begin
         if (bus.load) begin
            sh_digits <= bus.digits_in;
            sh_dp     <= bus.dp_in;
            sh_mask   <= bus.digit_mask;
            sh_bright <= bus.brightness;
         end
         if (frame_end) begin
            act_digits <= bus.load ? bus.digits_in  : sh_digits;
            act_dp     <= bus.load ? bus.dp_in      : sh_dp;
            act_mask   <= bus.load ? bus.digit_mask : sh_mask;
            act_bright <= bus.load ? bus.brightness : sh_bright;
         end
      end
   end

   always_comb begin
      on_limit  = (32'(act_bright) + 32'd1) * STEP;
      lit       = en && act_mask[idx] && (32'(presc) < on_limit);
      digit_sel = lit ? (NUM_DIGITS'(1) << idx) : '0;
      cur_nib   = act_digits[{idx, 2'b00} +: 4];
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (cur_nib),
      .glyph  (glyph)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode      <= {NUM_DIGITS{OFF}};
         seg        <= {7{OFF}};
         dp         <= OFF;
         frame_tick <= 1'b0;
      end else begin
         anode      <= digit_sel ^ {NUM_DIGITS{OFF}};
         seg        <= glyph ^ {7{OFF}};
         dp         <= act_dp[idx] ^ OFF;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: directed scenarios plus a random
// phase, compared against a time-based behavioural model.
module tb_display_scanner;

   localparam int N     = 4;
   localparam int RD    = 16;
   localparam int DB    = 2;
   localparam int AL    = 1;
   localparam int FRAME = N * RD;
   localparam int STEP  = RD / (1 << DB);

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       en    = 1'b0;
   logic [3:0] anode;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   display_scanner_if #(.NUM_DIGITS(N), .DIM_BITS(DB)) bus ();

   display_scanner #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (RD),
      .DIM_BITS    (DB),
      .ACTIVE_LOW  (AL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .bus        (bus),
      .anode      (anode),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int ft_seen = 0;

   // Model state: enabled cycles into the current frame plus shown/pending data.
   int         m_t;
   logic [15:0] m_dig,    s_dig;
   logic [3:0]  m_dpv,    s_dpv;
   logic [3:0]  m_mask,   s_mask;
   logic [1:0]  m_bright, s_bright;

   logic [6:0] glyph_ref [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic modelReset();
      m_t = 0;
      m_dig = '0;  s_dig = '0;
      m_dpv = '0;  s_dpv = '0;
      m_mask = '0; s_mask = '0;
      m_bright = 2'd3; s_bright = 2'd3;
   endtask

   // One clock: predict outputs from the pre-edge state, advance, compare.
   task automatic tick();
      int         slot;
      int         phase;
      logic       lit;
      logic [3:0] nib;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       e_ft;
      slot  = m_t / RD;
      phase = m_t % RD;
      lit   = en && m_mask[slot] && (phase < (int'(m_bright) + 1) * STEP);
      e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
      nib   = 4'(m_dig >> (4 * slot));
      e_seg = ~glyph_ref[nib];
      e_dp  = ~m_dpv[slot];
      e_ft  = en && (m_t == FRAME - 1);
      @(posedge clk);
      if (bus.load) begin
         s_dig    = bus.digits_in;
         s_dpv    = bus.dp_in;
         s_mask   = bus.digit_mask;
         s_bright = bus.brightness;
      end
      if (e_ft) begin
         m_dig    = s_dig;
         m_dpv    = s_dpv;
         m_mask   = s_mask;
         m_bright = s_bright;
      end
      if (en) m_t = (m_t + 1) % FRAME;
      @(negedge clk);
      checkOutput("anode", 32'(anode), 32'(e_an));
      checkOutput("seg", 32'(seg), 32'(e_seg));
      checkOutput("dp", 32'(dp), 32'(e_dp));
      checkOutput("frame_tick", 32'(frame_tick), 32'(e_ft));
      checkOutput("anode_onehot", 32'($countones(~anode) <= 1), 32'd1);
      ft_seen += int'(frame_tick);
   endtask

   task automatic applyStimulus(input logic [15:0] digs, input logic [3:0] dpv,
                                input logic [3:0] mask, input logic [1:0] bright);
      bus.digits_in  = digs;
      bus.dp_in      = dpv;
      bus.digit_mask = mask;
      bus.brightness = bright;
      bus.load       = 1'b1;
      tick();
      bus.load       = 1'b0;
   endtask

   task automatic runTo(input int target);
      for (int k = 0; k < FRAME && m_t != target; k++) tick();
   endtask

   initial begin
      int ft0;
      bus.load       = 1'b0;
      bus.digits_in  = '0;
      bus.dp_in      = '0;
      bus.digit_mask = '0;
      bus.brightness = '0;

      $display("[TB] reset and power-on state");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_anode", 32'(anode), 32'hF);
      checkOutput("rst_seg", 32'(seg), 32'h7F);
      checkOutput("rst_dp", 32'(dp), 32'h1);
      checkOutput("rst_frame_tick", 32'(frame_tick), 32'h0);
      modelReset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;

      $display("[TB] full brightness scan of 3A10");
      applyStimulus(16'h3A10, 4'($urandom), 4'hF, 2'd3);
      repeat (2 * FRAME) tick();
      ft0 = ft_seen;
      repeat (3 * FRAME) tick();
      checkOutput("frame_tick_count", 32'(ft_seen - ft0), 32'd3);

      $display("[TB] dimmed brightness levels");
      applyStimulus(16'h3A10, 4'($urandom), 4'hF, 2'd1);
      repeat (2 * FRAME) tick();
      applyStimulus(16'h3A10, 4'($urandom), 4'hF, 2'd0);
      repeat (2 * FRAME) tick();

      $display("[TB] digit 2 blanked");
      applyStimulus(16'h3A10, 4'($urandom), 4'b1011, 2'd3);
      repeat (2 * FRAME) tick();

      $display("[TB] mid-frame load and load on the wrap cycle");
      runTo(20);
      applyStimulus(16'($urandom), 4'($urandom), 4'hF, 2'($urandom));
      repeat (FRAME) tick();
      runTo(FRAME - 1);
      applyStimulus(16'($urandom), 4'($urandom), 4'hF, 2'd3);
      repeat (FRAME) tick();

      $display("[TB] enable dropped mid-slot");
      runTo(RD + 6);
      en = 1'b0;
      repeat (20) tick();
      en = 1'b1;
      repeat (FRAME) tick();

      $display("[TB] random phase");
      repeat (400) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0)
            applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
         else
            tick();
      end

      $display("[TB] asynchronous reset inside digit 2");
      en = 1'b1;
      applyStimulus(16'($urandom), 4'($urandom), 4'hF, 2'd3);
      repeat (2 * FRAME) tick();
      runTo(2 * RD + 5);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_anode", 32'(anode), 32'hF);
      checkOutput("async_rst_seg", 32'(seg), 32'h7F);
      checkOutput("async_rst_frame_tick", 32'(frame_tick), 32'h0);
      modelReset();
      @(negedge clk);
      checkOutput("held_rst_anode", 32'(anode), 32'hF);
      checkOutput("held_rst_seg", 32'(seg), 32'h7F);
      rst_n = 1'b1;
      applyStimulus(16'($urandom), 4'($urandom), 4'hF, 2'd3);
      repeat (2 * FRAME) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, range 2..16.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot, which SHALL be a multiple of 2**DIM_BITS.
REQ-003 The block SHALL have parameter DIM_BITS, default 4: brightness control width.
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1: 1 means anode and segment outputs are active-low; 0 means active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: scan enable.
REQ-008 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures the data inputs into the shadow registers.
REQ-009 The block SHALL have port digits_in, input, 4*NUM_DIGITS bits: hex nibble per digit, with digit 0 at bits [3:0].
REQ-010 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal point per digit.
REQ-011 The block SHALL have port digit_mask, input, NUM_DIGITS bits: 1 means the digit is shown, 0 means it is blanked.
REQ-012 The block SHALL have port brightness, input, DIM_BITS bits: duty-cycle level.
REQ-013 The block SHALL have port anode, output, NUM_DIGITS bits: one-hot digit select, polarity set by ACTIVE_LOW.
REQ-014 The block SHALL have port seg, output, 7 bits: segments a..g at bits 0..6, polarity set by ACTIVE_LOW.
REQ-015 The block SHALL have port dp, output, 1 bit: decimal point, polarity set by ACTIVE_LOW.
REQ-016 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-017 The prescaler SHALL count 0..REFRESH_DIV-1 while en=1, wrapping to 0; the digit index SHALL advance by one at each prescaler wrap.
REQ-018 The digit index SHALL wrap from NUM_DIGITS-1 to 0; frame_tick SHALL be 1 for exactly the cycle after that wrap.
REQ-019 On load=1, digits_in, dp_in, digit_mask and brightness SHALL be captured into shadow registers; the outputs SHALL NOT change as a result.
REQ-020 Shadow contents SHALL transfer to the active registers only at the frame wrap (index NUM_DIGITS-1 -> 0), so no frame mixes old and new data.
REQ-021 If load coincides with the frame-wrap cycle, the newly loaded values SHALL be the ones transferred.
REQ-022 The anode for the current index SHALL be asserted only while prescaler < brightness_act * (REFRESH_DIV / 2**DIM_BITS) + REFRESH_DIV / 2**DIM_BITS; brightness=max gives 100% duty and brightness=0 gives 1/2**DIM_BITS duty.
REQ-023 A digit with active mask bit 0 SHALL keep all anodes inactive for its entire slot; the slot timing SHALL be unchanged.
REQ-024 seg SHALL show the hex glyph (0-9, A-F) of the active nibble for the current index; dp SHALL follow the active dp bit.
REQ-025 All outputs SHALL be registered, with 1-cycle latency from an index or prescaler change to anode/seg/dp.
REQ-026 When en=0, the prescaler and index SHALL hold, all anodes SHALL be inactive and frame_tick SHALL be 0; scanning SHALL resume from the held state when en returns to 1.
REQ-027 At most one anode SHALL be active in any cycle.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear the prescaler, the index, and the shadow and active registers (except brightness, which resets to max) to 0, set all anodes and segments inactive at their configured polarity, and set frame_tick to 0.
REQ-029 A reset asserted mid-slot SHALL take effect immediately; after release the first slot SHALL be digit 0 with a full REFRESH_DIV length.

Structure
REQ-030 A shared package SHALL hold the 16-entry active-high hex-to-7-segment glyph table constant and the digit-index width function (clog2).
REQ-031 The block SHALL contain one combinational sub-module, hex_to_seg7 (nibble in, 7-bit active-high glyph out); polarity inversion SHALL be applied in display_scanner.

Verification (NUM_DIGITS=4, REFRESH_DIV=16, DIM_BITS=2, ACTIVE_LOW=1)
REQ-032 Load digits_in=16'h3A10, mask=4'hF, brightness=3 -> each anode is low for 16 cycles in order 1110, 1101, 1011, 0111; seg shows 0, 1, A, 3; frame_tick pulses every 64 cycles.
REQ-033 brightness=1 -> each anode is low for 8 of 16 cycles at the start of its slot; brightness=0 -> low for 4 cycles.
REQ-034 mask=4'b1011 -> digit 2 anode is never low; the other digits keep their 16-cycle slot positions.
REQ-035 Load new data mid-frame -> the outputs change only after the next frame_tick; the load on the frame-wrap cycle is applied in that same wrap.
REQ-036 Assert rst_n=0 at cycle 5 of digit 2 -> anode=4'hF and seg=7'h7F at once, with no clock edge required; after release digit 0 is first.
REQ-037 en=0 for 20 cycles mid-slot -> all anodes high, no frame_tick; the remaining slot length is preserved after en returns to 1.
